// File: rtl/mmio_uart_responder.sv
// mmio_uart_responder: memory-mapped target at MMIO_BASE that bridges CPU loads/stores to UART ready/valid ports.
// Latency: read data is registered and valid one cycle after the request; writes take effect at the next edge.
// Backpressure: uart_rx_ready drops when the RX FIFO is full; the TX holding register waits for uart_tx_ready.
//
// Optional feature: define MMIO_FIFO_LEVEL_EN to report RX FIFO occupancy in status[8:4].
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_we/req_addr/req_wdata : CPU access; req_we==0 is a read
//   rdata                               : registered read data, held until the next read
//   inst_retire                         : one instruction retired this cycle
//   uart_rx_data/_valid/_ready          : receiver byte stream into the RX FIFO
//   uart_tx_data/_valid/_ready          : TX holding register towards the transmitter
module mmio_uart_responder #(
   parameter int unsigned RX_FIFO_DEPTH = 4,
   parameter logic [31:0] MMIO_BASE     = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [3:0]  req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] rdata,
   input  logic        inst_retire,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_rx_valid,
   output logic        uart_rx_ready,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready
);

   localparam int unsigned PTR_W = $clog2(RX_FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [7:0] OFF_STATUS = 8'h00;
   localparam logic [7:0] OFF_RX     = 8'h04;
   localparam logic [7:0] OFF_TX     = 8'h08;
   localparam logic [7:0] OFF_CYC    = 8'h10;
   localparam logic [7:0] OFF_INST   = 8'h14;
   localparam logic [7:0] OFF_CLR    = 8'h18;

   // ---------------- request decode ----------------
   logic       hit, rd_req, wr_req, tx_wr, ctr_clr;
   logic [7:0] off;

   assign off     = req_addr[7:0];
   assign hit     = req_valid && (req_addr[31:28] == MMIO_BASE[31:28]);
   // Every read request updates rdata, including out-of-region ones (which return 0).
   assign rd_req  = req_valid && (req_we == 4'b0);
   assign wr_req  = hit && (req_we != 4'b0);
   assign tx_wr   = wr_req && (off == OFF_TX) && req_we[0];
   assign ctr_clr = wr_req && (off == OFF_CLR);

   logic unused_bits;
   assign unused_bits = ^{req_addr[27:8], req_wdata[31:8]};

   // ---------------- RX FIFO ----------------
   logic [7:0]       fifo_mem_q [RX_FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
   logic             fifo_empty, push, pop;

   assign fifo_empty    = (fifo_cnt_q == '0);
   assign uart_rx_ready = (fifo_cnt_q != CNT_W'(RX_FIFO_DEPTH));
   assign push          = uart_rx_valid && uart_rx_ready;
   assign pop           = rd_req && hit && (off == OFF_RX) && !fifo_empty;

   // Depth is a power of two, so the pointers wrap by natural overflow.
   assign wr_ptr_d   = wr_ptr_q + PTR_W'(push);
   assign rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
   assign fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);

   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= uart_rx_data;
   end

   // ---------------- TX holding register ----------------
   logic       tx_vld_q, tx_vld_d, tx_ovf_q, tx_ovf_d;
   logic [7:0] tx_dat_q, tx_dat_d;

   always_comb begin
      tx_vld_d = tx_vld_q;
      tx_dat_d = tx_dat_q;
      tx_ovf_d = tx_ovf_q;
      if (tx_vld_q) begin
         if (uart_tx_ready) tx_vld_d = 1'b0;
         // Register was busy when the store arrived (even on the handshake cycle): drop it.
         if (tx_wr) tx_ovf_d = 1'b1;
      end else if (tx_wr) begin
         tx_vld_d = 1'b1;
         tx_dat_d = req_wdata[7:0];
      end
      if (ctr_clr) tx_ovf_d = 1'b0;
   end

   assign uart_tx_valid = tx_vld_q;
   assign uart_tx_data  = tx_dat_q;

   // ---------------- counters ----------------
   logic [31:0] cyc_cnt_q, cyc_cnt_d, inst_cnt_q, inst_cnt_d;

   assign cyc_cnt_d  = ctr_clr ? 32'b0 : cyc_cnt_q + 32'd1;
   assign inst_cnt_d = ctr_clr ? 32'b0 : inst_cnt_q + {31'b0, inst_retire};

   // ---------------- read data ----------------
   logic [31:0] status, rdata_q, rdata_d;

   always_comb begin
      status    = 32'b0;
      status[0] = ~tx_vld_q;
      status[1] = ~fifo_empty;
      status[2] = tx_ovf_q;
`ifdef MMIO_FIFO_LEVEL_EN
      status[8:4] = 5'(fifo_cnt_q);
`endif
   end

   always_comb begin
      rdata_d = rdata_q;
      if (rd_req) begin
         rdata_d = 32'b0;
         if (hit) begin
            case (off)
               OFF_STATUS: rdata_d = status;
               OFF_RX:     rdata_d = fifo_empty ? 32'b0 : {24'b0, fifo_mem_q[rd_ptr_q]};
               OFF_CYC:    rdata_d = cyc_cnt_q;
               OFF_INST:   rdata_d = inst_cnt_q;
               default:    rdata_d = 32'b0;
            endcase
         end
      end
   end

   assign rdata = rdata_q;

   // ---------------- state registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         tx_vld_q   <= 1'b0;
         tx_dat_q   <= 8'b0;
         tx_ovf_q   <= 1'b0;
         cyc_cnt_q  <= 32'b0;
         inst_cnt_q <= 32'b0;
         rdata_q    <= 32'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         tx_vld_q   <= tx_vld_d;
         tx_dat_q   <= tx_dat_d;
         tx_ovf_q   <= tx_ovf_d;
         cyc_cnt_q  <= cyc_cnt_d;
         inst_cnt_q <= inst_cnt_d;
         rdata_q    <= rdata_d;
      end
   end

endmodule
